mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM-stage data-memory controller for the 5-stage RISC-V pipeline.
- Sits between the EX/MEM pipeline register and the MEM/WB control/data registers. Its RegWriteOutM, ResultSrcOutM and ReadDataM feed the MEM/WB registers.
- Issues load/store transactions on a req/ready data-memory port and generates byte enables and load sign/zero extension.
- Asserts StallM to the hazard unit while a transaction is outstanding.

Parameters:
- DATA_WIDTH, 32, data/address width; only 32 is supported.
- TIMEOUT_CYCLES, 255, BUSY-cycle limit when MEM_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- RegWriteM  in  1  register-write control from EX/MEM.
- ResultSrcM  in  2  result select from EX/MEM; 2'b01 = load.
- MemWriteM  in  1  store.
- Funct3M  in  3  access size/sign.
- ALUResultM  in  32  byte address.
- WriteDataM  in  32  store data, unaligned in lane 0.
- FlushM  in  1  kill the MEM-stage instruction.
- dmem_rdata  in  32  memory read word.
- dmem_ready  in  1  transaction complete.
- dmem_req  out  1  transaction request.
- dmem_we  out  1  write enable.
- dmem_addr  out  32  word address, bits[1:0] = 0.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- ReadDataM  out  32  extended load data.
- RegWriteOutM  out  1  RegWriteM, gated by fault.
- ResultSrcOutM  out  2  ResultSrcM passthrough.
- StallM  out  1  stall request to the hazard unit.
- AccessFaultM  out  1  one-cycle fault pulse.

Behaviour:
- Access: acc = (MemWriteM | ResultSrcM==2'b01) & ~FlushM.
- FSM states: IDLE, BUSY, DONE. Reset forces IDLE and clears all internal registers to 0, including captured address/data/funct3/we and rdata_q.
- Outputs under reset/IDLE with acc=0: dmem_req=0, StallM=0, AccessFaultM=0, ReadDataM=0, RegWriteOutM=RegWriteM.
- Fault check (combinational, IDLE only): fault when
  - Funct3M is 011, 110 or 111 with acc=1, or
  - halfword access with addr[0]=1, or
  - word access with addr[1:0]!=0.
- On fault:
  - no request; stay in IDLE; StallM=0.
  - AccessFaultM=1 and RegWriteOutM=0 for that cycle only.
- IDLE, acc=1, no fault:
  - capture addr, funct3, we, wdata, be; go to BUSY.
  - StallM=1 this cycle.
- BUSY:
  - dmem_req=1; dmem_* driven from captured registers; StallM=1.
  - On dmem_ready=1: rdata_q <= dmem_rdata; go to DONE.
  - FlushM is ignored in BUSY; a started transaction always completes.
- DONE:
  - StallM=0; ReadDataM = extend(rdata_q); go to IDLE unconditionally.
  - The EX/MEM register advances and MEM/WB captures in this cycle.
- Minimum access: ready on the first BUSY cycle gives 2 stall cycles; data is valid in the DONE cycle.
- Store encoding:
  - SB: be = 1<<addr[1:0]; wdata = {4{wd[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{wd[15:0]}}.
  - SW: be = 4'b1111.
  - Loads: be = 4'b1111, we = 0.
- Load extension (lane selected by captured addr[1:0]):
  - LB (000): sign-extend byte.
  - LH (001): sign-extend half.
  - LW (010): full word.
  - LBU (100): zero-extend byte.
  - LHU (101): zero-extend half.
- ReadDataM = 0 outside DONE.
- Stores complete identically; ReadDataM = 0 in their DONE cycle.
- Reset asserted mid-BUSY: immediately IDLE, dmem_req=0, captured data discarded.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - 8-bit BUSY counter, cleared on entering BUSY.
  - If it reaches TIMEOUT_CYCLES without dmem_ready: drop dmem_req, go to DONE with rdata_q=0.
  - In that DONE cycle: AccessFaultM=1 and RegWriteOutM=0.
- MEM_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely.

Test Plan:
- LW, addr 0x100, ready on first BUSY cycle, rdata 0xDEADBEEF:
  - dmem_addr=0x100, be=1111, StallM high 2 cycles.
  - DONE: ReadDataM=0xDEADBEEF, RegWriteOutM=1.
- LB/LBU, addr 0x103, rdata 0x80FF_FF7F:
  - LB → ReadDataM=0xFFFFFF80.
  - LBU → ReadDataM=0x00000080.
- SH, addr 0x202, WriteDataM 0x1234ABCD:
  - dmem_we=1, be=1100, wdata=0xABCDABCD, addr=0x200.
  - ReadDataM=0 in DONE.
- LW, addr 0x101:
  - no dmem_req, StallM=0, AccessFaultM=1 for one cycle, RegWriteOutM=0.
  - FSM stays in IDLE.
- Ready delayed 5 cycles, then rst pulsed in BUSY cycle 3:
  - dmem_req=0 and StallM=0 immediately; next access starts cleanly from IDLE.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, ready never asserted:
  - BUSY lasts 4 cycles, then DONE with AccessFaultM=1, ReadDataM=0, RegWriteOutM=0.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM-stage data-memory controller: req/ready port, byte enables, load extension, stall and fault.
// Optional BUSY timeout enabled by defining MEM_TIMEOUT_EN (parameter TIMEOUT_CYCLES).
module mem_access_stage #(
  parameter int unsigned DATA_WIDTH = 32
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic                  MemWriteM,
  input  logic [2:0]            Funct3M,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic                  FlushM,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  input  logic                  dmem_ready,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [3:0]            dmem_be,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  RegWriteOutM,
  output logic [1:0]            ResultSrcOutM,
  output logic                  StallM,
  output logic                  AccessFaultM
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [2:0]  f3_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic        to_q;

  logic        acc, fault, f3_bad, mis;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [7:0]  rb;
  logic [15:0] rh;
  logic [31:0] ext;
  logic        tfault;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] ToLast = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q;
`endif

  always_comb begin
    acc    = (MemWriteM | (ResultSrcM == 2'b01)) & ~FlushM;
    f3_bad = (Funct3M == 3'b011) | (Funct3M == 3'b110) | (Funct3M == 3'b111);
    mis    = ((Funct3M[1:0] == 2'b01) & ALUResultM[0]) |
             ((Funct3M[1:0] == 2'b10) & (ALUResultM[1:0] != 2'b00));
    fault  = (state_q == StIdle) & acc & (f3_bad | mis);

    be_n    = 4'b1111;
    wdata_n = WriteDataM;
    if (MemWriteM) begin
      case (Funct3M[1:0])
        2'b00:   be_n = 4'b0001 << ALUResultM[1:0];
        2'b01:   be_n = ALUResultM[1] ? 4'b1100 : 4'b0011;
        default: be_n = 4'b1111;
      endcase
    end
    case (Funct3M[1:0])
      2'b00:   wdata_n = {4{WriteDataM[7:0]}};
      2'b01:   wdata_n = {2{WriteDataM[15:0]}};
      default: wdata_n = WriteDataM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      to_q    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (acc && !fault) begin
            addr_q  <= ALUResultM;
            wdata_q <= wdata_n;
            f3_q    <= Funct3M;
            we_q    <= MemWriteM;
            be_q    <= be_n;
            to_q    <= 1'b0;
            state_q <= StBusy;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        StBusy: begin
          if (dmem_ready) begin
            rdata_q <= dmem_rdata;
            state_q <= StDone;
          end
`ifdef MEM_TIMEOUT_EN
          else if (cnt_q == ToLast) begin
            // Give up: complete with zero data and flag the fault in DONE.
            rdata_q <= '0;
            to_q    <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end
        default: begin
          to_q    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    case (addr_q[1:0])
      2'b00:   rb = rdata_q[7:0];
      2'b01:   rb = rdata_q[15:8];
      2'b10:   rb = rdata_q[23:16];
      default: rb = rdata_q[31:24];
    endcase
    rh = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (f3_q)
      3'b000:  ext = {{24{rb[7]}}, rb};
      3'b001:  ext = {{16{rh[15]}}, rh};
      3'b010:  ext = rdata_q;
      3'b100:  ext = {24'd0, rb};
      3'b101:  ext = {16'd0, rh};
      default: ext = '0;
    endcase

    tfault        = (state_q == StDone) & to_q;
    dmem_req      = (state_q == StBusy);
    dmem_we       = (state_q == StBusy) & we_q;
    dmem_addr     = {addr_q[31:2], 2'b00};
    dmem_wdata    = wdata_q;
    dmem_be       = be_q;
    StallM        = (state_q == StBusy) | ((state_q == StIdle) & acc & ~fault);
    AccessFaultM  = fault | tfault;
    RegWriteOutM  = RegWriteM & ~(fault | tfault);
    ResultSrcOutM = ResultSrcM;
    ReadDataM     = ((state_q == StDone) && !we_q) ? ext : '0;
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage; expected transactions go through a scoreboard queue.
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemWriteM, FlushM, dmem_ready;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM, dmem_rdata;
  logic        dmem_req, dmem_we, RegWriteOutM, StallM, AccessFaultM;
  logic [31:0] dmem_addr, dmem_wdata, ReadDataM;
  logic [3:0]  dmem_be;
  logic [1:0]  ResultSrcOutM;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic [3:0]  be;
    logic        we;
    logic        rw;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

`ifdef MEM_TIMEOUT_EN
  mem_access_stage #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
`else
  mem_access_stage #(.DATA_WIDTH(32)) dut (
`endif
    .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
    .MemWriteM(MemWriteM), .Funct3M(Funct3M), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .FlushM(FlushM), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .ReadDataM(ReadDataM), .RegWriteOutM(RegWriteOutM), .ResultSrcOutM(ResultSrcOutM),
    .StallM(StallM), .AccessFaultM(AccessFaultM)
  );

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*a +: 8];
    h = w[16*a[1] +: 16];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return w;
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return 32'd0;
    endcase
  endfunction

  task automatic set_idle_inputs();
    RegWriteM  = 1'b0;
    MemWriteM  = 1'b0;
    ResultSrcM = 2'b00;
    Funct3M    = 3'b000;
    ALUResultM = 32'd0;
    WriteDataM = 32'd0;
    FlushM     = 1'b0;
  endtask

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic rw);
    MemWriteM  = we;
    ResultSrcM = we ? 2'b00 : 2'b01;
    Funct3M    = f3;
    ALUResultM = addr;
    WriteDataM = wd;
    RegWriteM  = rw;
  endtask

  // One complete access; memory answers on BUSY cycle index 'delay'.
  task automatic run_access(input string name, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rdata, input int delay, input logic rw);
    exp_t e;
    int   stalls;
    int   c;
    bit   done;
    e.addr = {addr[31:2], 2'b00};
    e.we   = we;
    e.rw   = rw;
    e.rd   = we ? 32'd0 : model_load(f3, addr[1:0], rdata);
    case (f3[1:0])
      2'b00:   e.wdata = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
      2'b01:   e.wdata = {wd[15:0], wd[15:0]};
      default: e.wdata = wd;
    endcase
    if (!we)                 e.be = 4'b1111;
    else if (f3[1:0] == 2'b00) e.be = 4'b0001 << addr[1:0];
    else if (f3[1:0] == 2'b01) e.be = addr[1] ? 4'b1100 : 4'b0011;
    else                     e.be = 4'b1111;
    sb.push_back(e);

    @(negedge clk);
    drive(we, f3, addr, wd, rw);
    #1;
    checks++;
    if (StallM !== 1'b1 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: stall=%b req=%b, required stall=1 req=0", name, StallM, dmem_req);
    end
    stalls = 1;
    c = 0;
    done = 0;
    while (!done && c < 50) begin
      @(negedge clk);
      dmem_ready = (c == delay);
      dmem_rdata = (c == delay) ? rdata : 32'h5A5A_5A5A;
      #1;
      if (StallM === 1'b1) stalls++;
      if (c == 0) begin
        checks++;
        if (dmem_req !== 1'b1 || dmem_addr !== sb[0].addr || dmem_be !== sb[0].be ||
            dmem_we !== sb[0].we || (sb[0].we && dmem_wdata !== sb[0].wdata)) begin
          errors++;
          $display("FAIL %s busy: req=%b addr=%h be=%b we=%b wdata=%h, required 1 %h %b %b %h",
                   name, dmem_req, dmem_addr, dmem_be, dmem_we, dmem_wdata,
                   sb[0].addr, sb[0].be, sb[0].we, sb[0].wdata);
        end
      end
      if (dmem_ready) done = 1;
      c++;
    end
    if (!done) begin
      errors++;
      $display("FAIL %s ready never issued", name);
    end
    @(negedge clk);
    dmem_ready = 1'b0;
    #1;
    e = sb.pop_front();
    checks++;
    if (StallM !== 1'b0 || dmem_req !== 1'b0 || ReadDataM !== e.rd ||
        RegWriteOutM !== e.rw || AccessFaultM !== 1'b0 || stalls != delay + 2) begin
      errors++;
      $display("FAIL %s done: stall=%b req=%b rd=%h rw=%b flt=%b stalls=%0d, required 0 0 %h %b 0 %0d",
               name, StallM, dmem_req, ReadDataM, RegWriteOutM, AccessFaultM, stalls,
               e.rd, e.rw, delay + 2);
    end
    set_idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle_inputs();
    dmem_ready = 1'b0;
    dmem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    RegWriteM = 1'b1;
    ResultSrcM = 2'b10;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || StallM !== 1'b0 || AccessFaultM !== 1'b0 ||
        ReadDataM !== 32'd0 || RegWriteOutM !== 1'b1 || ResultSrcOutM !== 2'b10) begin
      errors++;
      $display("FAIL reset: req=%b stall=%b flt=%b rd=%h rw=%b rs=%b, required 0 0 0 0 1 10",
               dmem_req, StallM, AccessFaultM, ReadDataM, RegWriteOutM, ResultSrcOutM);
    end
    @(negedge clk);
    rst = 1'b0;
    set_idle_inputs();
    #1;
    checks++;
    if (RegWriteOutM !== 1'b0 || StallM !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: rw=%b stall=%b, required 0 0", RegWriteOutM, StallM);
    end
  endtask

  task automatic test_loads_stores();
    run_access("lw",  1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b1);
    run_access("lb",  1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_FF7F, 0, 1'b1);
    run_access("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_FF7F, 2, 1'b1);
    run_access("lh",  1'b0, 3'b001, 32'h102, 32'h0, 32'h8001_1234, 1, 1'b1);
    run_access("lhu", 1'b0, 3'b101, 32'h102, 32'h0, 32'h8001_1234, 0, 1'b1);
    run_access("lb0", 1'b0, 3'b000, 32'h104, 32'h0, 32'h1234_567F, 0, 1'b1);
    run_access("sh",  1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'hFFFF_FFFF, 0, 1'b0);
    run_access("sb",  1'b1, 3'b000, 32'h301, 32'h0000_115A, 32'h0, 1, 1'b0);
    run_access("sw",  1'b1, 3'b010, 32'h400, 32'hCAFE_F00D, 32'h0, 3, 1'b0);
  endtask

  task automatic test_fault();
    logic [2:0]  f3s[4]   = '{3'b010, 3'b001, 3'b011, 3'b101};
    logic [31:0] addrs[4] = '{32'h101, 32'h201, 32'h100, 32'h103};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b0, f3s[i], addrs[i], 32'h0, 1'b1);
      #1;
      checks++;
      if (AccessFaultM !== 1'b1 || RegWriteOutM !== 1'b0 || dmem_req !== 1'b0 ||
          StallM !== 1'b0) begin
        errors++;
        $display("FAIL fault%0d: flt=%b rw=%b req=%b stall=%b, required 1 0 0 0",
                 i, AccessFaultM, RegWriteOutM, dmem_req, StallM);
      end
      @(negedge clk);
      set_idle_inputs();
      #1;
      checks++;
      if (AccessFaultM !== 1'b0 || dmem_req !== 1'b0 || StallM !== 1'b0) begin
        errors++;
        $display("FAIL fault%0d_after: flt=%b req=%b stall=%b, required 0 0 0",
                 i, AccessFaultM, dmem_req, StallM);
      end
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    drive(1'b0, 3'b010, 32'h100, 32'h0, 1'b1);
    FlushM = 1'b1;
    #1;
    checks++;
    if (StallM !== 1'b0 || dmem_req !== 1'b0 || AccessFaultM !== 1'b0) begin
      errors++;
      $display("FAIL flush: stall=%b req=%b flt=%b, required 0 0 0", StallM, dmem_req, AccessFaultM);
    end
    @(negedge clk);
    #1;
    checks++;
    if (dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL flush_next: req=%b, required 0", dmem_req);
    end
    set_idle_inputs();
  endtask

  task automatic test_reset_mid_busy();
    @(negedge clk);
    drive(1'b0, 3'b010, 32'h500, 32'h0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      dmem_ready = 1'b0;
    end
    #1;
    checks++;
    if (dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_busy_pre: req=%b, required 1", dmem_req);
    end
    rst = 1'b1;
    set_idle_inputs();
    #1;
    checks++;
    if (dmem_req !== 1'b0 || StallM !== 1'b0 || ReadDataM !== 32'd0) begin
      errors++;
      $display("FAIL rst_busy: req=%b stall=%b rd=%h, required 0 0 0", dmem_req, StallM, ReadDataM);
    end
    @(negedge clk);
    rst = 1'b0;
    run_access("after_rst", 1'b0, 3'b010, 32'h600, 32'h0, 32'h0BAD_F00D, 1, 1'b1);
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int busy;
    int c;
    @(negedge clk);
    drive(1'b0, 3'b010, 32'h700, 32'h0, 1'b1);
    dmem_ready = 1'b0;
    busy = 0;
    c = 0;
    @(negedge clk);
    #1;
    while (dmem_req === 1'b1 && c < 20) begin
      busy++;
      c++;
      @(negedge clk);
      #1;
    end
    checks++;
    if (busy != 4 || AccessFaultM !== 1'b1 || ReadDataM !== 32'd0 || RegWriteOutM !== 1'b0 ||
        StallM !== 1'b0) begin
      errors++;
      $display("FAIL timeout: busy=%0d flt=%b rd=%h rw=%b stall=%b, required 4 1 0 0 0",
               busy, AccessFaultM, ReadDataM, RegWriteOutM, StallM);
    end
    set_idle_inputs();
  endtask
`endif

  initial begin
    test_reset();
    test_loads_stores();
    test_fault();
    test_flush();
    test_reset_mid_busy();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
